// File: rtl/fir_stereo_mac.sv
// Time-multiplexed stereo FIR: one shared multiplier walks TAPS coefficients
// for the left channel, then the right, then rounds/saturates both results.
module fir_stereo_mac #(
  parameter int TAPS = 16,
  parameter int DW   = 24,
  parameter int CW   = 16,
  parameter int FRAC = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_valid,
  input  logic [DW-1:0]             left_in,
  input  logic [DW-1:0]             right_in,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [CW-1:0]             coef_wdata,
  output logic [DW-1:0]             left_out,
  output logic [DW-1:0]             right_out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int AW  = $clog2(TAPS);
  localparam int PW  = DW + CW;
  localparam int ACW = PW + AW;

  localparam logic signed [ACW-1:0] HALF = ACW'(2 ** (FRAC - 1));
  localparam logic signed [ACW-1:0] MAXV = ACW'(2 ** (DW - 1) - 1);
  localparam logic signed [ACW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, MAC_L, MAC_R, ROUND} state_t;

  state_t state, state_nxt;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         tap;
  logic [AW-1:0]         rd_idx;
  logic [DW-1:0]         dl_l [TAPS];
  logic [DW-1:0]         dl_r [TAPS];
  logic [CW-1:0]         coef [TAPS];
  logic signed [ACW-1:0] acc;
  logic signed [ACW-1:0] acc_l;

  logic                  accept;
  logic                  coef_ok;
  logic                  last_tap;
  logic [DW-1:0]         x_sel;
  logic [CW-1:0]         c_sel;
  logic signed [PW-1:0]  x_ext;
  logic signed [PW-1:0]  c_ext;
  logic signed [PW-1:0]  prod;
  logic signed [ACW-1:0] prod_ext;
  logic signed [ACW-1:0] acc_sum;

  // The out_valid cycle counts as busy, so a new pair is only taken once
  // the previous result has been presented.
  assign busy     = (state != IDLE) || out_valid;
  assign accept   = sample_valid && !busy;
  assign coef_ok  = coef_we && !busy && !sample_valid;
  assign last_tap = (tap == AW'(TAPS - 1));

  // Newest sample sits one slot behind wr_ptr; tap k reaches back k more.
  assign rd_idx   = wr_ptr - AW'(1) - tap;
  assign x_sel    = (state == MAC_R) ? dl_r[rd_idx] : dl_l[rd_idx];
  assign c_sel    = coef[tap];
  assign x_ext    = {{CW{x_sel[DW-1]}}, x_sel};
  assign c_ext    = {{DW{c_sel[CW-1]}}, c_sel};
  assign prod     = x_ext * c_ext;
  assign prod_ext = {{AW{prod[PW-1]}}, prod};
  assign acc_sum  = acc + prod_ext;

  function automatic logic [DW-1:0] sat_round(input logic signed [ACW-1:0] a);
    logic signed [ACW-1:0] r;
    r = (a + HALF) >>> FRAC;
    if (r > MAXV)
      return {1'b0, {(DW-1){1'b1}}};
    else if (r < MINV)
      return {1'b1, {(DW-1){1'b0}}};
    else
      return r[DW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = MAC_L;
      MAC_L:   if (last_tap) state_nxt = MAC_R;
      MAC_R:   if (last_tap) state_nxt = ROUND;
      ROUND:                 state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      tap       <= '0;
      acc       <= '0;
      acc_l     <= '0;
      left_out  <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        dl_l[i] <= '0;
        dl_r[i] <= '0;
        coef[i] <= '0;
      end
      coef[0] <= CW'(2 ** FRAC);
    end else begin
      out_valid <= 1'b0;

      if (sample_valid && busy)
        overrun <= 1'b1;

      if (accept) begin
        dl_l[wr_ptr] <= left_in;
        dl_r[wr_ptr] <= right_in;
        wr_ptr       <= wr_ptr + AW'(1);
        acc          <= '0;
        tap          <= '0;
      end

      if (coef_ok)
        coef[coef_addr] <= coef_wdata;

      case (state)
        MAC_L: begin
          tap <= tap + AW'(1);
          if (last_tap) begin
            acc_l <= acc_sum;
            acc   <= '0;
          end else begin
            acc   <= acc_sum;
          end
        end
        MAC_R: begin
          tap <= tap + AW'(1);
          acc <= acc_sum;
        end
        ROUND: begin
          left_out  <= sat_round(acc_l);
          right_out <= sat_round(acc);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fir_stereo_mac.md
Name: fir_stereo_mac

Overview:
- Time-multiplexed stereo FIR filter directly downstream of the I2S/PCM1808 receiver.
- Consumes each left/right 24-bit sample pair on the receiver's one-cycle sample-valid strobe (one pair per 256 clk at Fs = 46.875 kHz).
- Runs a TAPS-length multiply-accumulate per channel on one shared multiplier and presents the filtered pair with a one-cycle valid strobe.
- Coefficients are runtime-writable, so the EQ/control logic can reprogram the response.

Parameters:
- TAPS, 16, filter length; power of 2, from 4 to 64.
- DW, 24, sample width, signed two's complement.
- CW, 16, coefficient width, signed Q1.FRAC.
- FRAC, 14, coefficient fractional bits; 1.0 = 2^FRAC.

Ports:
- clk  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  one-cycle strobe; left_in/right_in valid this cycle.
- left_in  in  DW  signed left sample.
- right_in  in  DW  signed right sample.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  log2(TAPS)  coefficient index k.
- coef_wdata  in  CW  signed coefficient value.
- left_out  out  DW  filtered left, held until the next result.
- right_out  out  DW  filtered right, held until the next result.
- out_valid  out  1  one-cycle strobe; new left_out/right_out valid.
- busy  out  1  MAC sequence in progress.
- overrun  out  1  sticky; a sample_valid arrived while busy.

Behaviour:
- Interface: clock clk; reset is synchronous, active-high.
- Reset state:
  - left_out=0, right_out=0, out_valid=0, busy=0, overrun=0.
  - Both delay lines cleared to 0; write pointer=0.
  - Coefficients c[0]=2^FRAC (identity response), c[1..TAPS-1]=0.
  - FSM=IDLE.
- Delay lines: two circular buffers of TAPS entries, indexed modulo TAPS. x[n-k] is the entry k positions behind the newest.
- FSM states: IDLE, MAC_L, MAC_R, ROUND.
  - IDLE: when sample_valid=1, write left_in/right_in at wr_ptr, advance wr_ptr modulo TAPS, clear the accumulator, go to MAC_L.
  - MAC_L: TAPS cycles, k=0..TAPS-1; acc += xL[n-k]*c[k]. After the last tap, store accL and go to MAC_R.
  - MAC_R: same TAPS cycles on the right channel into accR; then go to ROUND.
  - ROUND: register the outputs, pulse out_valid, return to IDLE.
- Arithmetic:
  - Products are DW+CW bits; the accumulator is DW+CW+log2(TAPS) bits, signed, and never wraps.
  - Output = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half up.
  - Saturate to the DW range: above 2^(DW-1)-1 gives 0x7FFFFF; below -2^(DW-1) gives 0x800000.
- Latency:
  - sample_valid accepted in cycle T gives out_valid=1 in cycle T+2*TAPS+2 (T+34 at defaults), for exactly one cycle.
  - busy=1 from T+1 through the out_valid cycle inclusive.
  - left_out and right_out update in the same cycle that out_valid rises.
- sample_valid while busy: the sample is discarded (delay lines and wr_ptr unchanged), overrun is set and stays 1 until reset, and the current computation completes unaffected.
- Coefficient writes:
  - coef_we is applied at the clock edge only when FSM=IDLE and sample_valid=0.
  - It is ignored (no effect) when busy or when coinciding with an accepted sample_valid, so one output never mixes coefficient sets.
- Reset mid-operation: the computation aborts, no out_valid is produced, and all state returns to reset values, including coefficients.
- wr_ptr wraps from TAPS-1 to 0 with no discontinuity in history.

Test Plan:
- Identity: after reset, left_in=0x100000 and right_in=0xF00000 (negative) with sample_valid at T -> at T+34, out_valid=1, left_out=0x100000, right_out=0xF00000, busy=0 at T+35.
- Step response: write c[0..3]=0x1000 (0.25), others 0; feed left_in=0x400000 every 256 clk -> successive left_out 0x100000, 0x200000, 0x300000, 0x400000, 0x400000.
- Rounding: c[0]=0x2000 (0.5), others 0; left_in=3 -> left_out=2; left_in=-3 -> left_out=0xFFFFFF (-1).
- Saturation: c[0]=c[1]=0x4000; left_in=0x600000 twice -> second left_out=0x7FFFFF; repeat with 0xA00000 -> second left_out=0x800000.
- Overrun and coefficient guard:
  - sample_valid at T and T+5 -> exactly one out_valid (T+34), computed from the T sample; overrun=1 from T+6 and held.
  - coef_we at T+10 has no effect on the next result.
- Reset mid-op: reset at T+20 -> no out_valid; outputs 0; next sample gives the identity response again; wrap check: 40 consecutive samples with TAPS=16 give correct outputs across the wr_ptr wrap.
